// File: rtl/datapath_seq.sv
// datapath_seq: register file + ALU + MAR/MBR datapath that runs one command
// (ALU, LOAD, STORE, NOP) per valid/ready handshake and sequences external
// memory over a req/ack handshake, retiring each command with a done pulse.
// Optional build macro: DATAPATH_SEQ_STICKY_FLAGS_EN (ALU flags accumulate
// until flag_clr instead of being overwritten by every ALU op).
//
// state | meaning
// IDLE  | ready for a command; done pulses here after a retire
// EXEC  | ALU result written, or MAR/MBR_out set up for memory
// MEM   | mem_req held high until mem_ack
// WB    | LOAD data moved from MBR_in into the register file
module datapath_seq #(
    parameter int N    = 8,
    parameter int NREG = 4,
    parameter int AW   = 8,
    localparam int RA  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [RA-1:0] cmd_rd,
    input  logic [RA-1:0] cmd_ra,
    input  logic [RA-1:0] cmd_rb,
    input  logic [1:0]    cmd_func,
    input  logic          cmd_comp,
    input  logic          cmd_ci,
    output logic          done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata,
    input  logic          mem_ack,
    input  logic          flag_clr,
    output logic          alu_so,
    output logic          alu_uo,
    input  logic [RA-1:0] dbg_sel,
    output logic [N-1:0]  dbg_data
);
    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

    localparam logic [1:0] OP_ALU   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    state_t        state, state_nx;
    logic [N-1:0]  regs [NREG];
    logic [N-1:0]  mar, mbr_out, mbr_in;
    logic [1:0]    op_q, func_q;
    logic [RA-1:0] rd_q, ra_q, rb_q;
    logic          comp_q, ci_q;
    logic          done_q, so_q, uo_q;

    logic          accept, alu_wr, load_addr, store_setup, load_cap, wb_wr, retire;
    logic [N-1:0]  a, b, q;
    logic [N:0]    sum;
    logic          so_n, uo_n;

    // ALU on the latched command; operands are read before the write edge
    always_comb begin
        a    = regs[ra_q];
        b    = comp_q ? ~regs[rb_q] : regs[rb_q];
        sum  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci_q};
        q    = sum[N-1:0];
        so_n = 1'b0;
        uo_n = 1'b0;
        case (func_q)
            2'b00: q = a & b;
            2'b01: q = a | b;
            2'b10: q = a ^ b;
            default: begin
                uo_n = sum[N] ^ comp_q;
                so_n = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic and per-state datapath strobes
    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        alu_wr      = 1'b0;
        load_addr   = 1'b0;
        store_setup = 1'b0;
        load_cap    = 1'b0;
        wb_wr       = 1'b0;
        retire      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_ALU: begin
                        alu_wr   = 1'b1;
                        retire   = 1'b1;
                        state_nx = IDLE;
                    end
                    OP_LOAD: begin
                        load_addr = 1'b1;
                        state_nx  = MEM;
                    end
                    OP_STORE: begin
                        store_setup = 1'b1;
                        state_nx    = MEM;
                    end
                    default: begin
                        retire   = 1'b1;
                        state_nx = IDLE;
                    end
                endcase
            end
            MEM: begin
                if (mem_ack) begin
                    if (op_q == OP_LOAD) begin
                        load_cap = 1'b1;
                        state_nx = WB;
                    end else begin
                        retire   = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            WB: begin
                wb_wr    = 1'b1;
                retire   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Command latch, register file, MAR/MBR, flags and the done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            mar     <= '0;
            mbr_out <= '0;
            mbr_in  <= '0;
            op_q    <= '0;
            func_q  <= '0;
            rd_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            comp_q  <= 1'b0;
            ci_q    <= 1'b0;
            so_q    <= 1'b0;
            uo_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= retire;
            if (accept) begin
                op_q   <= cmd_op;
                rd_q   <= cmd_rd;
                ra_q   <= cmd_ra;
                rb_q   <= cmd_rb;
                func_q <= cmd_func;
                comp_q <= cmd_comp;
                ci_q   <= cmd_ci;
            end
            if (alu_wr)     regs[rd_q] <= q;
            else if (wb_wr) regs[rd_q] <= mbr_in;
            if (load_addr) mar <= q;
            if (store_setup) begin
                mar     <= regs[ra_q];
                mbr_out <= regs[rb_q];
            end
            if (load_cap) mbr_in <= mem_rdata;
            // flag_clr wins over an ALU update on the same edge
            if (flag_clr) begin
                so_q <= 1'b0;
                uo_q <= 1'b0;
            end else if (alu_wr) begin
`ifdef DATAPATH_SEQ_STICKY_FLAGS_EN
                so_q <= so_q | so_n;
                uo_q <= uo_q | uo_n;
`else
                so_q <= so_n;
                uo_q <= uo_n;
`endif
            end
        end
    end

    assign cmd_ready = (state == IDLE);
    assign mem_req   = (state == MEM);
    assign mem_we    = (state == MEM) && (op_q == OP_STORE);
    assign mem_addr  = mar[AW-1:0];
    assign mem_wdata = mbr_out;
    assign done      = done_q;
    assign alu_so    = so_q;
    assign alu_uo    = uo_q;
    assign dbg_data  = regs[dbg_sel];
endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq (N=8, NREG=4, AW=8) with hand-computed
// expectations; also covers the DATAPATH_SEQ_STICKY_FLAGS_EN build.
module tb_datapath_seq;
`ifdef DATAPATH_SEQ_STICKY_FLAGS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_func;
    logic       cmd_comp, cmd_ci;
    logic       done, mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_ack, flag_clr, alu_so, alu_uo;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    int errors = 0;
    int checks = 0;

    datapath_seq #(.N(8), .NREG(4), .AW(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_func(cmd_func), .cmd_comp(cmd_comp), .cmd_ci(cmd_ci),
        .done(done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .flag_clr(flag_clr),
        .alu_so(alu_so), .alu_uo(alu_uo),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        dbg_sel = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic chk_flags(input string tag, input logic so, input logic uo);
        check({tag, " so"}, alu_so, so);
        check({tag, " uo"}, alu_uo, uo);
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
    endtask

    // Issue one command, act as memory, and measure edges from accept to done
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [1:0] rd,
                           input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] func,
                           input logic comp, input logic ci, input int exp_lat,
                           input int ack_wait, input logic ack_idle, input logic [7:0] rdata,
                           input logic [7:0] exp_addr, input logic [7:0] exp_wdata);
        int lat;
        int memc;
        check({tag, " ready"}, cmd_ready, 1'b1);
        cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
        cmd_func = func; cmd_comp = comp; cmd_ci = ci;
        cmd_valid = 1'b1;
        mem_ack = ack_idle;
        step();
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_rd = 2'($urandom); cmd_ra = 2'($urandom);
        cmd_rb = 2'($urandom); cmd_func = 2'($urandom);
        cmd_comp = 1'($urandom); cmd_ci = 1'($urandom);
        lat = 1;
        memc = 0;
        while (done !== 1'b1 && lat < 30) begin
            if (mem_req === 1'b1) begin
                if (memc == 0 || memc == ack_wait) begin
                    check({tag, " addr"}, mem_addr, exp_addr);
                    check({tag, " we"}, mem_we, (op == 2'b10));
                    if (op == 2'b10) check({tag, " wdata"}, mem_wdata, exp_wdata);
                end
                mem_ack = (memc >= ack_wait);
                mem_rdata = rdata;
                memc++;
            end else begin
                mem_ack = ack_idle;
            end
            step();
            lat++;
        end
        mem_ack = 1'b0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " req off"}, mem_req, 1'b0);
        check({tag, " ready@done"}, cmd_ready, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b11; cmd_rd = 2'd0;
        cmd_ra = 2'd0; cmd_rb = 2'd0; cmd_func = 2'd0; cmd_comp = 1'b0; cmd_ci = 1'b0;
        mem_rdata = 8'h00; mem_ack = 1'b0; flag_clr = 1'b0; dbg_sel = 2'd0;
        step(); step();
        reset_n = 1'b1;
        step();

        // Reset state
        check("rst ready", cmd_ready, 1'b1);
        check("rst done", done, 1'b0);
        check("rst req", mem_req, 1'b0);
        check("rst we", mem_we, 1'b0);
        check("rst addr", mem_addr, 8'h00);
        check("rst wdata", mem_wdata, 8'h00);
        chk_flags("rst", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chk_reg("rst reg", 2'(i), 8'h00);

        // ADD r1 = r0+r0+1, then ADD r2 = r1+r1 (mem_ack held high: ignored outside MEM)
        run_cmd("add1", 2'b00, 2'd1, 2'd0, 2'd0, 2'b11, 1'b0, 1'b1, 2, 0, 1'b1, 8'h00, 8'h00, 8'h00);
        chk_reg("add1 r1", 2'd1, 8'h01);
        run_cmd("add2", 2'b00, 2'd2, 2'd1, 2'd1, 2'b11, 1'b0, 1'b0, 2, 0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk_reg("add2 r2", 2'd2, 8'h02);
        chk_flags("add2", 1'b0, 1'b0);

        // LOAD r1 <- mem[r0&r0 = 0x00] = 0x7F, ack in first MEM cycle
        run_cmd("ld7f", 2'b01, 2'd1, 2'd0, 2'd0, 2'b00, 1'b0, 1'b0, 4, 0, 1'b0, 8'h7F, 8'h00, 8'h00);
        chk_reg("ld7f r1", 2'd1, 8'h7F);
        run_cmd("one", 2'b00, 2'd2, 2'd0, 2'd0, 2'b11, 1'b0, 1'b1, 2, 0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk_reg("one r2", 2'd2, 8'h01);

        // ADD r3 = 0x7F + 0x01 = 0x80: signed overflow
        run_cmd("ovf", 2'b00, 2'd3, 2'd1, 2'd2, 2'b11, 1'b0, 1'b0, 2, 0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk_reg("ovf r3", 2'd3, 8'h80);
        chk_flags("ovf", 1'b1, 1'b0);

        // SUB r0 = r2 - r1 = 0x01 - 0x7F = 0x82 with borrow
        run_cmd("sub", 2'b00, 2'd0, 2'd2, 2'd1, 2'b11, 1'b1, 1'b1, 2, 0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk_reg("sub r0", 2'd0, 8'h82);
        chk_flags("sub", STICKY, 1'b1);

        // Build STORE operands by LOAD; flags must not change
        run_cmd("ld10", 2'b01, 2'd2, 2'd1, 2'd1, 2'b00, 1'b0, 1'b0, 4, 0, 1'b0, 8'h10, 8'h7F, 8'h00);
        chk_reg("ld10 r2", 2'd2, 8'h10);
        chk_flags("ld10", STICKY, 1'b1);
        run_cmd("lda5", 2'b01, 2'd3, 2'd3, 2'd3, 2'b00, 1'b0, 1'b0, 4, 0, 1'b0, 8'hA5, 8'h80, 8'h00);
        chk_reg("lda5 r3", 2'd3, 8'hA5);

        // STORE mem[0x10] = 0xA5, ack 3 cycles late
        run_cmd("st", 2'b10, 2'd0, 2'd2, 2'd3, 2'b00, 1'b0, 1'b0, 6, 3, 1'b1, 8'h00, 8'h10, 8'hA5);
        chk_flags("st", STICKY, 1'b1);

        // LOAD r0 <- mem[0x10] = 0x3C
        run_cmd("ld3c", 2'b01, 2'd0, 2'd2, 2'd2, 2'b00, 1'b0, 1'b0, 4, 0, 1'b0, 8'h3C, 8'h10, 8'hA5);
        chk_reg("ld3c r0", 2'd0, 8'h3C);
        chk_flags("ld3c", STICKY, 1'b1);

        pulse_clr();
        chk_flags("clr1", 1'b0, 1'b0);

        // Overflowing ADD then clean ADD: sticky keeps so
        run_cmd("sov", 2'b00, 2'd3, 2'd1, 2'd2, 2'b11, 1'b0, 1'b0, 2, 0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk_reg("sov r3", 2'd3, 8'h8F);
        chk_flags("sov", 1'b1, 1'b0);
        run_cmd("sok", 2'b00, 2'd3, 2'd2, 2'd2, 2'b11, 1'b0, 1'b0, 2, 0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk_reg("sok r3", 2'd3, 8'h20);
        chk_flags("sok", STICKY, 1'b0);
        pulse_clr();
        chk_flags("clr2", 1'b0, 1'b0);

        // flag_clr held through an overflowing ADD wins over the update
        flag_clr = 1'b1;
        run_cmd("clrpri", 2'b00, 2'd3, 2'd1, 2'd2, 2'b11, 1'b0, 1'b0, 2, 0, 1'b0, 8'h00, 8'h00, 8'h00);
        flag_clr = 1'b0;
        chk_reg("clrpri r3", 2'd3, 8'h8F);
        chk_flags("clrpri", 1'b0, 1'b0);

        // rd == ra == rb uses old value: 0x7F + 0x7F = 0xFE
        run_cmd("self", 2'b00, 2'd1, 2'd1, 2'd1, 2'b11, 1'b0, 1'b0, 2, 0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk_reg("self r1", 2'd1, 8'hFE);
        chk_flags("self", 1'b1, 1'b0);

        // XOR 0xFE ^ 0x8F = 0x71; logic ops give zero flags
        run_cmd("xor", 2'b00, 2'd2, 2'd1, 2'd3, 2'b10, 1'b0, 1'b0, 2, 0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk_reg("xor r2", 2'd2, 8'h71);
        chk_flags("xor", STICKY, 1'b0);

        // OR with complement, rd == rb: 0x71 | ~0x3C = 0xF3
        run_cmd("orc", 2'b00, 2'd0, 2'd2, 2'd0, 2'b01, 1'b1, 1'b0, 2, 0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk_reg("orc r0", 2'd0, 8'hF3);

        // NOP retires without touching state; done is one cycle wide
        run_cmd("nop", 2'b11, 2'd1, 2'd0, 2'd0, 2'b11, 1'b0, 1'b1, 2, 0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk_reg("nop r1", 2'd1, 8'hFE);
        step();
        check("done pulse", done, 1'b0);

        // Reset while in MEM aborts the LOAD
        cmd_op = 2'b01; cmd_rd = 2'd0; cmd_ra = 2'd1; cmd_rb = 2'd1; cmd_func = 2'b00;
        cmd_comp = 1'b0; cmd_ci = 1'b0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        check("abort req", mem_req, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("abort req low", mem_req, 1'b0);
        check("abort ready", cmd_ready, 1'b1);
        check("abort done", done, 1'b0);
        step(); step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) chk_reg("abort reg", 2'(i), 8'h00);
        check("abort addr", mem_addr, 8'h00);
        chk_flags("abort", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort no done", done, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
